// File: rtl/cim_shift_accumulator.sv
// cim_shift_accumulator
// Bit-serial shift-and-add accumulator behind the CIM macro. Each operation
// delivers INPUT_BIT_WIDTH partial-sum beats, MSB first. The beats are folded
// into one full-precision result vector. Results queue in a 2-entry FIFO with a
// valid/ready handshake toward the back end.
//
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   psum_valid    partial-sum beat present this cycle
//   in_msb        marks the beat as the first (MSB) beat of an operation
//   psum_data     NUM_COL unsigned partial sums, PSUM_WIDTH bits each
//   out_valid     output FIFO non-empty
//   out_ready     consumer accepts the head entry
//   out_data      head entry, NUM_COL results of ACC_WIDTH bits each
//   acc_busy      an accumulation is in progress
//   protocol_err  sticky: orphan beat or early restart
//   overrun_err   sticky: result dropped because the FIFO was full
//   err_clear     clears both sticky flags (a same-cycle set wins)
module cim_shift_accumulator #(
  parameter int unsigned INPUT_BIT_WIDTH = 4,
  parameter int unsigned NUM_COL         = 16,
  parameter int unsigned PSUM_WIDTH      = 7,
  parameter bit          SIGNED_INPUT    = 1'b0,
  localparam int unsigned ACC_WIDTH      = PSUM_WIDTH + INPUT_BIT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           psum_valid,
  input  logic                           in_msb,
  input  logic [NUM_COL*PSUM_WIDTH-1:0]  psum_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_COL*ACC_WIDTH-1:0]   out_data,
  output logic                           acc_busy,
  output logic                           protocol_err,
  output logic                           overrun_err,
  input  logic                           err_clear
);

  localparam int unsigned AccVecW = NUM_COL * ACC_WIDTH;
  localparam int unsigned CntW    = (INPUT_BIT_WIDTH > 1) ? $clog2(INPUT_BIT_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(INPUT_BIT_WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AccVecW-1:0]  acc_q, acc_d;
  logic [AccVecW-1:0]  first_vec, shift_vec;
  logic                push, proto_set;

  // Per-column candidates: MSB-beat load and shift-and-add continuation.
  // The MSB beat carries negative weight for two's complement inputs.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH-1:0] acc_col;
    assign ext     = ACC_WIDTH'(psum_data[c*PSUM_WIDTH +: PSUM_WIDTH]);
    assign acc_col = acc_q[c*ACC_WIDTH +: ACC_WIDTH];
    assign first_vec[c*ACC_WIDTH +: ACC_WIDTH] = SIGNED_INPUT ? (ACC_WIDTH'(0) - ext) : ext;
    assign shift_vec[c*ACC_WIDTH +: ACC_WIDTH] = {acc_col[ACC_WIDTH-2:0], 1'b0} + ext;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    push      = 1'b0;
    proto_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psum_valid) begin
          if (in_msb) begin
            acc_d = first_vec;
            if (INPUT_BIT_WIDTH == 1) begin
              // Single-beat operations complete on the MSB beat itself.
              push = 1'b1;
            end else begin
              cnt_d   = CntW'(1);
              state_d = StAcc;
            end
          end else begin
            proto_set = 1'b1;
          end
        end
      end
      StAcc: begin
        if (psum_valid) begin
          if (in_msb) begin
            // Early restart: drop the partial result, start over with this beat.
            proto_set = 1'b1;
            acc_d     = first_vec;
            cnt_d     = CntW'(1);
          end else begin
            acc_d = shift_vec;
            if (cnt_q == CntLast) begin
              push    = 1'b1;
              cnt_d   = '0;
              state_d = StIdle;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  assign acc_busy = (state_q == StAcc);

  // 2-entry output FIFO.
  logic [AccVecW-1:0] mem_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         count_q, count_d;
  logic               pop, full, push_ok, drop;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign full      = (count_q == 2'd2);
  // When full, a same-cycle pop frees the head slot, which is the write slot.
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop)     rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_q[wr_ptr_q] <= acc_d;
    end
  end

  // Sticky error flags; set has priority over clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      if (proto_set)      protocol_err <= 1'b1;
      else if (err_clear) protocol_err <= 1'b0;
      if (drop)           overrun_err  <= 1'b1;
      else if (err_clear) overrun_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cim_shift_accumulator.sv
// Testbench for cim_shift_accumulator. An unsigned and a signed instance share
// stimulus; expected result vectors are queued per instance when an operation
// is issued and a monitor compares them against each popped FIFO head.
module tb_cim_shift_accumulator;

  localparam int NC = 16;
  localparam int PW = 7;
  localparam int AW = 11;
  localparam int VW = NC * AW;

  logic               clk, rst_n, psum_valid, in_msb, out_ready, err_clear;
  logic [NC*PW-1:0]   psum_data;
  logic               out_valid_u, acc_busy_u, protocol_err_u, overrun_err_u;
  logic               out_valid_s, acc_busy_s, protocol_err_s, overrun_err_s;
  logic [VW-1:0]      out_data_u, out_data_s;

  int checks   = 0;
  int failures = 0;
  logic [VW-1:0] q_u[$];
  logic [VW-1:0] q_s[$];

  cim_shift_accumulator #(.INPUT_BIT_WIDTH(4), .NUM_COL(NC), .PSUM_WIDTH(PW),
                          .SIGNED_INPUT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .psum_valid(psum_valid), .in_msb(in_msb),
    .psum_data(psum_data), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_data(out_data_u), .acc_busy(acc_busy_u), .protocol_err(protocol_err_u),
    .overrun_err(overrun_err_u), .err_clear(err_clear)
  );

  cim_shift_accumulator #(.INPUT_BIT_WIDTH(4), .NUM_COL(NC), .PSUM_WIDTH(PW),
                          .SIGNED_INPUT(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .psum_valid(psum_valid), .in_msb(in_msb),
    .psum_data(psum_data), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .acc_busy(acc_busy_s), .protocol_err(protocol_err_s),
    .overrun_err(overrun_err_s), .err_clear(err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Column c value of a beat: base, or base+c when spread is set.
  function automatic int colv(input int base, input bit spread, input int c);
    return spread ? ((base + c) & 127) : base;
  endfunction

  function automatic logic [NC*PW-1:0] mk(input int base, input bit spread);
    logic [NC*PW-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++) r[c*PW +: PW] = 7'(colv(base, spread, c));
    return r;
  endfunction

  // Hand formula: unsigned 8*b0+4*b1+2*b2+b3, signed -8*b0+4*b1+2*b2+b3.
  function automatic logic [VW-1:0] expv(input int b0, input int b1, input int b2,
                                         input int b3, input bit spread, input bit sgn);
    logic [VW-1:0] r;
    int s;
    r = '0;
    for (int c = 0; c < NC; c++) begin
      s = 4 * colv(b1, spread, c) + 2 * colv(b2, spread, c) + colv(b3, spread, c);
      s = sgn ? s - 8 * colv(b0, spread, c) : s + 8 * colv(b0, spread, c);
      r[c*AW +: AW] = 11'(s);
    end
    return r;
  endfunction

  task automatic beat(input bit msb, input int base, input bit spread);
    psum_valid = 1'b1;
    in_msb     = msb;
    psum_data  = mk(base, spread);
    @(posedge clk); #1;
    psum_valid = 1'b0;
    in_msb     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic op4(input int b0, input int b1, input int b2, input int b3,
                     input bit spread, input bit keep);
    if (keep) begin
      q_u.push_back(expv(b0, b1, b2, b3, spread, 1'b0));
      q_s.push_back(expv(b0, b1, b2, b3, spread, 1'b1));
    end
    beat(1'b1, b0, spread);
    beat(1'b0, b1, spread);
    beat(1'b0, b2, spread);
    beat(1'b0, b3, spread);
  endtask

  task automatic clear_pulse();
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid_u"}, VW'(out_valid_u), '0);
    chk({tag, "_valid_s"}, VW'(out_valid_s), '0);
    chk({tag, "_data_u"}, out_data_u, '0);
    chk({tag, "_data_s"}, out_data_s, '0);
    chk({tag, "_busy"}, VW'({acc_busy_u, acc_busy_s}), '0);
    chk({tag, "_errs"}, VW'({protocol_err_u, overrun_err_u, protocol_err_s, overrun_err_s}), '0);
  endtask

  // Monitor: compare every accepted head entry against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid_u && out_ready) begin
        if (q_u.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_u actual=%0h required=no_output", out_data_u);
        end else chk("result_u", out_data_u, q_u.pop_front());
      end
      if (out_valid_s && out_ready) begin
        if (q_s.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_s actual=%0h required=no_output", out_data_s);
        end else chk("result_s", out_data_s, q_s.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; psum_valid = 1'b0; in_msb = 1'b0; psum_data = '0;
    out_ready = 1'b1; err_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Basic operation: col0 = 30 unsigned, -18 signed; latency 1 after last beat.
    op4(3, 1, 0, 2, 1'b1, 1'b1);
    chk("latency_valid", VW'({out_valid_u, out_valid_s}), VW'(2'b11));
    chk("col0_u", VW'(out_data_u[AW-1:0]), VW'(11'd30));
    chk("col0_s", VW'(out_data_s[AW-1:0]), VW'(11'h7EE));
    idle(2);

    // Full-scale beats: 1905 unsigned, -127 signed.
    op4(127, 127, 127, 127, 1'b0, 1'b1);
    idle(2);

    // Back-to-back operations.
    op4(1, 2, 3, 4, 1'b1, 1'b1);
    op4(10, 20, 30, 40, 1'b1, 1'b1);
    idle(3);

    // Gaps between beats hold state; col0 = 63 unsigned.
    q_u.push_back(expv(5, 2, 7, 1, 1'b1, 1'b0));
    q_s.push_back(expv(5, 2, 7, 1, 1'b1, 1'b1));
    beat(1'b1, 5, 1'b1);
    idle(1);
    chk("gap_busy1", VW'({acc_busy_u, acc_busy_s}), VW'(2'b11));
    idle(1);
    beat(1'b0, 2, 1'b1);
    idle(1);
    chk("gap_busy2", VW'({acc_busy_u, acc_busy_s}), VW'(2'b11));
    beat(1'b0, 7, 1'b1);
    chk("gap_busy3", VW'({acc_busy_u, acc_busy_s}), VW'(2'b11));
    beat(1'b0, 1, 1'b1);
    chk("gap_done_busy", VW'({acc_busy_u, acc_busy_s}), '0);
    chk("gap_col0_u", VW'(out_data_u[AW-1:0]), VW'(11'd63));
    idle(2);

    // Overrun: third result dropped while the consumer stalls.
    out_ready = 1'b0;
    op4(2, 3, 4, 5, 1'b1, 1'b1);
    op4(6, 7, 8, 9, 1'b1, 1'b1);
    chk("pre_overrun", VW'({overrun_err_u, overrun_err_s}), '0);
    op4(11, 12, 13, 14, 1'b1, 1'b0);
    chk("overrun_set", VW'({overrun_err_u, overrun_err_s}), VW'(2'b11));
    chk("overrun_proto", VW'({protocol_err_u, protocol_err_s}), '0);
    chk("stall_head_u", out_data_u, expv(2, 3, 4, 5, 1'b1, 1'b0));
    out_ready = 1'b1;
    idle(3);
    chk("drained", VW'({out_valid_u, out_valid_s}), '0);
    chk("overrun_sticky", VW'({overrun_err_u, overrun_err_s}), VW'(2'b11));
    clear_pulse();
    chk("overrun_clear", VW'({overrun_err_u, overrun_err_s}), '0);

    // Orphan beat in IDLE, then restart mid-operation.
    beat(1'b0, 9, 1'b1);
    chk("orphan_err", VW'({protocol_err_u, protocol_err_s}), VW'(2'b11));
    chk("orphan_busy", VW'({acc_busy_u, acc_busy_s}), '0);
    chk("orphan_novalid", VW'({out_valid_u, out_valid_s}), '0);
    clear_pulse();
    chk("proto_clear", VW'({protocol_err_u, protocol_err_s}), '0);
    beat(1'b1, 9, 1'b1);
    beat(1'b0, 4, 1'b1);
    op4(8, 6, 3, 1, 1'b1, 1'b1);
    chk("restart_err", VW'({protocol_err_u, protocol_err_s}), VW'(2'b11));
    idle(2);
    clear_pulse();

    // Reset mid-accumulation, then a clean operation.
    beat(1'b1, 20, 1'b1);
    beat(1'b0, 21, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("midreset");
    rst_n = 1'b1;
    op4(4, 0, 5, 9, 1'b1, 1'b1);
    idle(2);

    for (int i = 0; i < 50 && (q_u.size() != 0 || q_s.size() != 0); i++) idle(1);
    chk("scoreboard_empty", VW'(q_u.size() + q_s.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
